// File: rtl/ats21_pkg.sv
// ---------------------------------------------------------------------------
// ats21_pkg
// Shared definitions for the ATS21 command issuer slice: the ATS21
// instruction opcodes, the issuer FSM state encoding, bus widths and a
// small helper that identifies commands that are completed locally.
// ---------------------------------------------------------------------------
package ats21_pkg;

    localparam int NUM_ALARMS = 24;
    localparam int CMD_W      = 32;
    localparam int BEAT_W     = 16;

    // ATS21 instruction opcodes, carried in cmd[31:29]
    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_SET_CLK = 3'b001,
        OP_EN_CLK  = 3'b010,
        OP_MODE    = 3'b011,
        OP_SET_ALM = 3'b101,
        OP_SET_TMR = 3'b110,
        OP_EN_ALM  = 3'b111
    } ats21_opcode_e;

    // Issuer FSM states, in the order a device command walks through them
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4,
        ST_GAPW = 3'd5
    } issuer_state_e;

    // A NOP never reaches the device; it is answered by the issuer itself
    function automatic logic is_local_op(input logic [2:0] opcode);
        return opcode == OP_NOP;
    endfunction

endpackage

// File: rtl/ats21_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// ats21_cmd_issuer_if
// Host-side command/response handshake of the ATS21 command issuer.
//   cmd_valid / cmd_data / cmd_ready : command offer, accepted on valid & ready
//   rsp_valid / rsp_ack / rsp_local  : one-cycle completion report
// Modports:
//   master : the host (drives commands, receives responses)
//   slave  : the issuer (accepts commands, drives responses)
// ---------------------------------------------------------------------------
interface ats21_cmd_issuer_if;
    import ats21_pkg::*;

    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_data;
    logic             cmd_ready;
    logic             rsp_valid;
    logic             rsp_ack;
    logic             rsp_local;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_ack,
        input  rsp_local
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_ack,
        output rsp_local
    );

endinterface

// File: rtl/ats21_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ats21_cmd_fifo
// Synchronous command FIFO with a first-word-fall-through read port.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   push, push_data    : write strobe and data
//   pop, pop_data      : read strobe; pop_data always shows the head entry
//   full, empty        : occupancy flags
// A push while full is still honoured when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ats21_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit tells a full FIFO from an empty one
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both strobes may act in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ---------------------------------------------------------------------------
// ats21_cmd_issuer
// Client-side initiator for one ATS21 control port. Buffers 32-bit host
// commands, sends each as two 16-bit beats (high half first) on ctrl with
// req, samples the port's stat bit as Ack/Nack and reports a response.
// NOP commands are answered locally without touching the device.
// Independently, rising edges on the ATS21 alarm data bus are captured into
// sticky, write-1-to-clear event bits with a registered interrupt.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   host           : command/response handshake (slave modport)
//   req, ctrl      : device request and 16-bit control beat
//   stat_in        : device status bit, 1 = Ack
//   alarm_data     : device alarm bits
//   evt_clr        : write-1-to-clear mask for evt_pending
//   evt_pending    : sticky rising-edge events
//   evt_irq        : registered OR of evt_pending
//   busy           : a command is in flight or waiting in the FIFO
// ---------------------------------------------------------------------------
module ats21_cmd_issuer #(
    parameter int CMD_DEPTH  = 4,
    parameter int STAT_LAT   = 1,
    parameter int GAP        = 1,
    parameter int NUM_ALARMS = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ats21_cmd_issuer_if.slave     host,
    output logic                  req,
    output logic [15:0]           ctrl,
    input  logic                  stat_in,
    input  logic [NUM_ALARMS-1:0] alarm_data,
    input  logic [NUM_ALARMS-1:0] evt_clr,
    output logic [NUM_ALARMS-1:0] evt_pending,
    output logic                  evt_irq,
    output logic                  busy
);
    import ats21_pkg::*;

    // One counter serves both the status wait and the inter-command gap
    localparam int CNT_MAX = (STAT_LAT > GAP) ? STAT_LAT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    issuer_state_e     state;
    issuer_state_e     state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CMD_W-1:0]  cmd_q;
    logic              cmd_local;
    logic              ready_en;

    logic              fifo_push;
    logic              fifo_pop;
    logic [CMD_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    logic              req_d;
    logic [15:0]       ctrl_d;
    logic              rsp_valid_d;
    logic              rsp_ack_d;
    logic              rsp_local_d;
    logic              rsp_valid_q;
    logic              rsp_ack_q;
    logic              rsp_local_q;

    logic [NUM_ALARMS-1:0] alarm_q;

    // Host handshake: ready is held low until the first clock after reset
    assign host.cmd_ready = ready_en && !fifo_full;
    assign fifo_push      = host.cmd_valid && host.cmd_ready;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_ack   = rsp_ack_q;
    assign host.rsp_local = rsp_local_q;
    assign busy           = (state != ST_IDLE) || !fifo_empty;

    ats21_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (host.cmd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register plus the per-command context and the registered
    // outputs. Outputs are registered from the current state, so each beat
    // appears on the pins one cycle after the FSM sits in HI or LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cmd_q       <= '0;
            cmd_local   <= 1'b0;
            ready_en    <= 1'b0;
            req         <= 1'b0;
            ctrl        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= 1'b0;
            rsp_local_q <= 1'b0;
        end else begin
            state       <= state_next;
            ready_en    <= 1'b1;
            req         <= req_d;
            ctrl        <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_local_q <= rsp_local_d;
            // Counter restarts on every state change and runs within a state
            if (state_next != state) cnt <= '0;
            else                     cnt <= cnt + 1'b1;
            if (fifo_pop) begin
                cmd_q     <= fifo_head;
                cmd_local <= is_local_op(fifo_head[31:29]);
            end
        end
    end

    // Next-state logic. WAIT lasts STAT_LAT cycles so that the RESP cycle,
    // where stat_in is captured, falls STAT_LAT cycles after the visible
    // low beat. Local NOPs skip the gap entirely.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_next = is_local_op(fifo_head[31:29]) ? ST_RESP : ST_HI;
            end
            ST_HI:   state_next = ST_LO;
            ST_LO:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (cnt == CNT_W'(STAT_LAT - 1)) state_next = ST_RESP;
            end
            ST_RESP: state_next = cmd_local ? ST_IDLE : ST_GAPW;
            ST_GAPW: begin
                if (cnt == CNT_W'(GAP - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: values loaded into the output registers at the end of
    // the current state, plus the combinational FIFO pop strobe
    always_comb begin
        fifo_pop    = 1'b0;
        req_d       = 1'b0;
        ctrl_d      = '0;
        rsp_valid_d = 1'b0;
        rsp_ack_d   = 1'b0;
        rsp_local_d = 1'b0;
        case (state)
            ST_IDLE: fifo_pop = !fifo_empty;
            ST_HI: begin
                req_d  = 1'b1;
                ctrl_d = cmd_q[31:16];
            end
            ST_LO: begin
                req_d  = 1'b1;
                ctrl_d = cmd_q[15:0];
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_local_d = cmd_local;
                rsp_ack_d   = cmd_local ? 1'b0 : stat_in;
            end
            default: ;
        endcase
    end

    // Alarm event capture: a new rising edge beats a simultaneous clear so
    // that an event arriving during the clear is never lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q     <= '0;
            evt_pending <= '0;
            evt_irq     <= 1'b0;
        end else begin
            alarm_q     <= alarm_data;
            evt_pending <= (evt_pending & ~evt_clr) | (alarm_data & ~alarm_q);
            evt_irq     <= |evt_pending;
        end
    end

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_ats21_cmd_issuer
// Self-checking bench for ats21_cmd_issuer. Expected beats and responses are
// queued when a command is accepted and compared by a monitor as the DUT
// produces them; a small device model drives stat_in at the sample cycle.
// ---------------------------------------------------------------------------
module tb_ats21_cmd_issuer;

    localparam int CMD_DEPTH  = 4;
    localparam int STAT_LAT   = 1;
    localparam int GAP        = 1;
    localparam int NUM_ALARMS = 24;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  req;
    logic [15:0]           ctrl;
    logic                  stat_in = 1'b0;
    logic [NUM_ALARMS-1:0] alarm_data = '0;
    logic [NUM_ALARMS-1:0] evt_clr = '0;
    logic [NUM_ALARMS-1:0] evt_pending;
    logic                  evt_irq;
    logic                  busy;

    ats21_cmd_issuer_if host_if ();

    ats21_cmd_issuer #(
        .CMD_DEPTH  (CMD_DEPTH),
        .STAT_LAT   (STAT_LAT),
        .GAP        (GAP),
        .NUM_ALARMS (NUM_ALARMS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host        (host_if),
        .req         (req),
        .ctrl        (ctrl),
        .stat_in     (stat_in),
        .alarm_data  (alarm_data),
        .evt_clr     (evt_clr),
        .evt_pending (evt_pending),
        .evt_irq     (evt_irq),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] exp_beats[$];
    logic [1:0]  exp_rsp[$];   // {local, ack}
    logic        ack_plan[$];

    int   push_cyc;
    logic push_waited;
    int   hi_cyc, lo_cyc, rsp_cyc, rsp_cnt;
    int   beat_idx, min_gap;
    logic have_lo;
    int   dev_beat, stat_cnt;
    logic cur_ack;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every beat and response against the scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            beat_idx = 0;
        end else begin
            if (req) begin
                n_checks++;
                if (exp_beats.size() == 0) begin
                    $display("[TB] FAIL unexpected_req: ctrl=%h, no beat expected", ctrl);
                end else begin
                    logic [15:0] e;
                    e = exp_beats.pop_front();
                    if (ctrl !== e) $display("[TB] FAIL beat: got %h expected %h", ctrl, e);
                    else n_pass++;
                end
                if (beat_idx == 0) begin
                    if (have_lo && (cyc - lo_cyc - 1) < min_gap) min_gap = cyc - lo_cyc - 1;
                    hi_cyc   = cyc;
                    beat_idx = 1;
                end else begin
                    lo_cyc   = cyc;
                    have_lo  = 1'b1;
                    beat_idx = 0;
                end
            end
            if (host_if.rsp_valid) begin
                logic [1:0] r;
                n_checks++;
                if (exp_rsp.size() == 0) begin
                    $display("[TB] FAIL unexpected_rsp: local=%b ack=%b, none expected",
                             host_if.rsp_local, host_if.rsp_ack);
                end else begin
                    r = exp_rsp.pop_front();
                    if ({host_if.rsp_local, host_if.rsp_ack} !== r)
                        $display("[TB] FAIL rsp: got local/ack=%b%b expected %b",
                                 host_if.rsp_local, host_if.rsp_ack, r);
                    else n_pass++;
                    if (r[1] == 1'b0) begin
                        n_checks++;
                        if (cyc - lo_cyc !== STAT_LAT + 1)
                            $display("[TB] FAIL rsp_latency: got %0d expected %0d",
                                     cyc - lo_cyc, STAT_LAT + 1);
                        else n_pass++;
                    end
                end
                rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    // Device model: stat_in carries the planned answer only in the sample
    // cycle and its inverse while waiting, so a mistimed sample is caught
    always @(negedge clk) begin
        if (!reset_n) begin
            stat_cnt = 0;
            dev_beat = 0;
            stat_in  = 1'b0;
        end else begin
            if (stat_cnt > 0) begin
                stat_cnt--;
                stat_in = (stat_cnt == 0) ? cur_ack : ~cur_ack;
            end else begin
                stat_in = 1'b0;
            end
            if (req && dev_beat == 1) begin
                cur_ack  = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
                stat_cnt = STAT_LAT;
                stat_in  = ~cur_ack;
                dev_beat = 0;
            end else if (req) begin
                dev_beat = 1;
            end
        end
    end

    // Offer a command at a negedge; returns at the negedge after acceptance
    // with cmd_valid still high so the caller can chain or withdraw it
    task automatic push_cmd(input logic [31:0] cmd, input logic ack);
        int t;
        t = 0;
        push_waited = 1'b0;
        host_if.cmd_valid = 1'b1;
        host_if.cmd_data  = cmd;
        while (host_if.cmd_ready !== 1'b1 && t < 200) begin
            push_waited = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            $display("[TB] FAIL push_timeout: cmd_ready=%b required 1", host_if.cmd_ready);
            host_if.cmd_valid = 1'b0;
        end else begin
            @(negedge clk);
            push_cyc = cyc;
            if (cmd[31:29] == 3'b000) begin
                exp_rsp.push_back(2'b10);
            end else begin
                exp_beats.push_back(cmd[31:16]);
                exp_beats.push_back(cmd[15:0]);
                exp_rsp.push_back({1'b0, ack});
                ack_plan.push_back(ack);
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy !== 1'b0 || exp_rsp.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            $display("[TB] FAIL idle_timeout: busy=%b pending_rsp=%0d required 0/0",
                     busy, exp_rsp.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        host_if.cmd_valid = 1'b0;
        host_if.cmd_data  = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req, ctrl, host_if.rsp_valid, host_if.rsp_ack, host_if.rsp_local,
             evt_pending, evt_irq, busy} !== '0)
            $display("[TB] FAIL reset_outputs: req=%b ctrl=%h rsp=%b%b%b evt=%h irq=%b busy=%b required all 0",
                     req, ctrl, host_if.rsp_valid, host_if.rsp_ack, host_if.rsp_local,
                     evt_pending, evt_irq, busy);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (host_if.cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL ready_after_reset: ready=%b busy=%b required 1/0",
                     host_if.cmd_ready, busy);
        else n_pass++;
    endtask

    task automatic test_single_cmd();
        int start_rsp;
        start_rsp = rsp_cnt;
        push_cmd(32'h2440_0010, 1'b1);
        host_if.cmd_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (hi_cyc - push_cyc !== 2)
            $display("[TB] FAIL req_latency: got %0d required 2", hi_cyc - push_cyc);
        else n_pass++;
        n_checks++;
        if (rsp_cnt - start_rsp !== 1)
            $display("[TB] FAIL single_rsp_count: got %0d required 1", rsp_cnt - start_rsp);
        else n_pass++;
    endtask

    task automatic test_nop();
        int start_rsp;
        start_rsp = rsp_cnt;
        push_cmd(32'h0000_1234, 1'b0);
        host_if.cmd_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (rsp_cnt - start_rsp !== 1 || rsp_cyc - push_cyc !== 2)
            $display("[TB] FAIL nop_rsp: count=%0d latency=%0d required 1/2",
                     rsp_cnt - start_rsp, rsp_cyc - push_cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] cmds [6];
        logic        acks [6];
        int          start_rsp;
        cmds = '{32'h2000_0001, 32'h4000_0002, 32'h6000_0003,
                 32'hA000_0004, 32'hC000_0005, 32'hE000_0006};
        acks = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        start_rsp = rsp_cnt;
        min_gap   = 1000;
        for (int i = 0; i < 6; i++) begin
            push_cmd(cmds[i], acks[i]);
            if (i == 4) begin
                n_checks++;
                if (host_if.cmd_ready !== 1'b0)
                    $display("[TB] FAIL full_ready: got %b required 0", host_if.cmd_ready);
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if (push_waited !== 1'b1)
                    $display("[TB] FAIL sixth_waited: got %b required 1", push_waited);
                else n_pass++;
            end
        end
        host_if.cmd_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (rsp_cnt - start_rsp !== 6)
            $display("[TB] FAIL b2b_rsp_count: got %0d required 6", rsp_cnt - start_rsp);
        else n_pass++;
        n_checks++;
        if (min_gap < GAP)
            $display("[TB] FAIL req_gap: got %0d required >= %0d", min_gap, GAP);
        else n_pass++;
    endtask

    task automatic test_nack();
        int start_rsp;
        start_rsp = rsp_cnt;
        push_cmd(32'hA300_0050, 1'b0);
        push_cmd(32'h2440_0011, 1'b1);
        host_if.cmd_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (rsp_cnt - start_rsp !== 2)
            $display("[TB] FAIL nack_rsp_count: got %0d required 2", rsp_cnt - start_rsp);
        else n_pass++;
    endtask

    task automatic test_events();
        alarm_data = 24'h000008;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h000008 || evt_irq !== 1'b0)
            $display("[TB] FAIL evt_rise: pending=%h irq=%b required 000008/0", evt_pending, evt_irq);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h000008 || evt_irq !== 1'b1)
            $display("[TB] FAIL evt_irq: pending=%h irq=%b required 000008/1", evt_pending, evt_irq);
        else n_pass++;
        alarm_data = '0;
        @(negedge clk);
        alarm_data = 24'h000008;
        evt_clr    = 24'h000008;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h000008)
            $display("[TB] FAIL evt_set_wins: pending=%h required 000008", evt_pending);
        else n_pass++;
        evt_clr = '0;
        @(negedge clk);
        evt_clr = 24'h000008;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h000000 || evt_irq !== 1'b1)
            $display("[TB] FAIL evt_clear: pending=%h irq=%b required 000000/1", evt_pending, evt_irq);
        else n_pass++;
        evt_clr = '0;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h000000 || evt_irq !== 1'b0)
            $display("[TB] FAIL evt_irq_drop: pending=%h irq=%b required 000000/0", evt_pending, evt_irq);
        else n_pass++;
        alarm_data = 24'h800009;
        @(negedge clk);
        n_checks++;
        if (evt_pending !== 24'h800001)
            $display("[TB] FAIL evt_multi: pending=%h required 800001", evt_pending);
        else n_pass++;
        alarm_data = '0;
        evt_clr    = '1;
        @(negedge clk);
        evt_clr = '0;
        n_checks++;
        if (evt_pending !== 24'h000000)
            $display("[TB] FAIL evt_clear_all: pending=%h required 000000", evt_pending);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t;
        int start_rsp;
        push_cmd(32'h6000_00FF, 1'b1);
        host_if.cmd_valid = 1'b0;
        t = 0;
        while (!(req === 1'b1 && ctrl === 16'h00FF) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            $display("[TB] FAIL lo_beat_timeout: ctrl=%h required 00ff", ctrl);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (req !== 1'b0 || ctrl !== 16'h0000)
            $display("[TB] FAIL reset_drop: req=%b ctrl=%h required 0/0000", req, ctrl);
        else n_pass++;
        exp_beats.delete();
        exp_rsp.delete();
        ack_plan.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_rsp = rsp_cnt;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || host_if.cmd_ready !== 1'b1)
            $display("[TB] FAIL post_reset_idle: busy=%b ready=%b required 0/1",
                     busy, host_if.cmd_ready);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rsp_cnt !== start_rsp)
            $display("[TB] FAIL abandoned_rsp: got %0d responses required 0", rsp_cnt - start_rsp);
        else n_pass++;
        push_cmd(32'hE000_0042, 1'b0);
        host_if.cmd_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (rsp_cnt - start_rsp !== 1)
            $display("[TB] FAIL post_reset_cmd: got %0d responses required 1", rsp_cnt - start_rsp);
        else n_pass++;
    endtask

    initial begin
        rsp_cnt  = 0;
        hi_cyc   = 0;
        lo_cyc   = 0;
        rsp_cyc  = 0;
        have_lo  = 1'b0;
        beat_idx = 0;
        min_gap  = 1000;
        cur_ack  = 1'b0;
        test_reset();
        test_single_cmd();
        test_nop();
        test_back_to_back();
        test_nack();
        test_events();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
